// File: rtl/i2s_sample_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_sample_tx_pkg
//  Description : Shared sample width, signed sample type and transmitter
//                state encoding used by the synth and the I2S transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2s_sample_tx_pkg;

  localparam int c_SAMPLE_W = 20;

  typedef logic signed [c_SAMPLE_W-1:0] sample_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sample_fifo
//  Description : Single-clock sample FIFO with occupancy output. A push while
//                full and a pop while empty are ignored; a simultaneous push
//                and pop both take effect.
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_LVL_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_LVL_W-1:0] r_level;
  logic               w_push_ok;
  logic               w_pop_ok;

  assign full      = (r_level == c_LVL_W'(DEPTH));
  assign empty     = (r_level == '0);
  assign level     = r_level;
  assign pop_data  = r_mem[r_rd_ptr];
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;

  // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + c_LVL_W'(1);
        2'b01:   r_level <= r_level - c_LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/i2s_sample_tx.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_sample_tx
//  Description : Mono 20-bit sample to standard I2S transmitter. One FIFO
//                entry is consumed per frame and sent in both slots, MSB one
//                bit clock after the word-select edge, zero padded.
//                Build option I2S_TX_UNDERFLOW_HOLD_EN: repeat the last sample
//                on underflow instead of sending zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_sample_tx
  import i2s_sample_tx_pkg::*;
#(
  parameter int BCLK_DIV   = 8,
  parameter int SLOT_BITS  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  sample_t                       sample_in,
  input  logic                          sample_valid,
  input  logic                          clear_flags,
  output logic                          i2s_bclk,
  output logic                          i2s_lrclk,
  output logic                          i2s_sdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int c_HALF  = BCLK_DIV / 2;
  localparam int c_DIV_W = (c_HALF > 1) ? $clog2(c_HALF) : 1;
  localparam int c_CNT_W = $clog2(2 * SLOT_BITS);
  localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(c_HALF - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(2 * SLOT_BITS - 1);
  localparam logic [c_CNT_W-1:0] c_SLOT      = c_CNT_W'(SLOT_BITS);
  localparam logic [c_CNT_W-1:0] c_DATA_LAST = c_CNT_W'(c_SAMPLE_W);

  tx_state_e               r_state;
  logic [c_DIV_W-1:0]      r_div_cnt;
  logic [c_CNT_W-1:0]      r_bit_cnt;
  logic                    r_bclk;
  logic                    r_lrclk;
  logic                    r_sdata;
  logic [c_SAMPLE_W-1:0]   r_shreg;
  sample_t                 r_last;
  logic                    r_overflow;
  logic                    r_underflow;

  logic                    w_fall;
  logic                    w_wrap;
  logic [c_CNT_W-1:0]      w_next_cnt;
  logic [c_CNT_W-1:0]      w_slot_pos;
  logic                    w_data_bit;
  sample_t                 w_subst;
  sample_t                 w_load_sample;
  sample_t                 w_fifo_data;
  logic                    w_fifo_full;
  logic                    w_fifo_empty;

`ifdef I2S_TX_UNDERFLOW_HOLD_EN
  assign w_subst = r_last;
`else
  assign w_subst = '0;
`endif

  // Falling-edge detection, next bit count and position of that bit inside its slot.
  always_comb begin
    w_fall        = r_bclk && (r_div_cnt == c_DIV_LAST);
    w_wrap        = w_fall && (r_bit_cnt == c_CNT_LAST);
    w_next_cnt    = w_wrap ? '0 : (r_bit_cnt + c_CNT_W'(1));
    w_slot_pos    = (w_next_cnt >= c_SLOT) ? (w_next_cnt - c_SLOT) : w_next_cnt;
    w_data_bit    = (w_slot_pos != '0) && (w_slot_pos <= c_DATA_LAST);
    w_load_sample = w_fifo_empty ? w_subst : w_fifo_data;
  end

  sample_fifo #(
    .WIDTH (c_SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (sample_valid),
    .push_data (sample_in),
    .pop       (w_wrap),
    .pop_data  (w_fifo_data),
    .level     (fifo_level),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty)
  );

  // Bit-clock divider, frame counter, IDLE->RUN sequencing and serial shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_bclk    <= 1'b0;
      r_lrclk   <= 1'b0;
      r_sdata   <= 1'b0;
      r_shreg   <= '0;
      r_last    <= '0;
    end else begin
      if (r_div_cnt == c_DIV_LAST) begin
        r_div_cnt <= '0;
        r_bclk    <= ~r_bclk;
      end else begin
        r_div_cnt <= r_div_cnt + c_DIV_W'(1);
      end
      if (w_fall) begin
        r_bit_cnt <= w_next_cnt;
        r_lrclk   <= (w_next_cnt >= c_SLOT);
        if (w_wrap) begin
          // Frame boundary: take this frame's sample; slot bit 0 is always padding.
          r_state <= ST_RUN;
          r_last  <= w_load_sample;
          r_shreg <= w_load_sample;
          r_sdata <= 1'b0;
        end else if (w_next_cnt == c_SLOT) begin
          // Right slot repeats the same frame sample.
          r_shreg <= r_last;
          r_sdata <= 1'b0;
        end else if (w_data_bit && (r_state == ST_RUN)) begin
          r_sdata <= r_shreg[c_SAMPLE_W-1];
          r_shreg <= {r_shreg[c_SAMPLE_W-2:0], 1'b0};
        end else begin
          r_sdata <= 1'b0;
        end
      end
    end
  end

  // Sticky error flags; a set event in the same cycle as a clear keeps the flag high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (sample_valid && w_fifo_full) r_overflow <= 1'b1;
      else if (clear_flags)            r_overflow <= 1'b0;
      if (w_wrap && w_fifo_empty)      r_underflow <= 1'b1;
      else if (clear_flags)            r_underflow <= 1'b0;
    end
  end

  assign i2s_bclk  = r_bclk;
  assign i2s_lrclk = r_lrclk;
  assign i2s_sdata = r_sdata;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_i2s_sample_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2s_sample_tx
//  Description : Self-checking bench for i2s_sample_tx. Expected outputs are
//                derived from the clock count since reset release and a
//                queue-based FIFO model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_sample_tx;

  localparam int c_HALF  = 4;
  localparam int c_PER   = 8;
  localparam int c_SLOT  = 32;
  localparam int c_FRAME = 512;
  localparam int c_DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic [19:0] sample_in;
  logic        sample_valid;
  logic        clear_flags;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_sdata;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic        underflow;

  int checks   = 0;
  int failures = 0;

  i2s_sample_tx #(
    .BCLK_DIV   (8),
    .SLOT_BITS  (32),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .clear_flags  (clear_flags),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrclk    (i2s_lrclk),
    .i2s_sdata    (i2s_sdata),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  int          n_m;       // rising clk edges since reset release
  logic [19:0] q[$];      // FIFO contents
  logic [19:0] fs;        // sample of the current frame
  bit          ov_m;
  bit          uf_m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_m  = 0;
      q.delete();
      fs   = '0;
      ov_m = 1'b0;
      uf_m = 1'b0;
    end else begin
      int s;
      bit ovs;
      bit ufs;
      s   = q.size();
      ovs = 1'b0;
      ufs = 1'b0;
      if ((n_m + 1) % c_FRAME == 0) begin
        if (s > 0) fs = q.pop_front();
        else begin
          ufs = 1'b1;
`ifndef I2S_TX_UNDERFLOW_HOLD_EN
          fs = '0;
`endif
        end
      end
      if (sample_valid) begin
        if (s < c_DEPTH) q.push_back(sample_in);
        else ovs = 1'b1;
      end
      ov_m = ovs ? 1'b1 : (clear_flags ? 1'b0 : ov_m);
      uf_m = ufs ? 1'b1 : (clear_flags ? 1'b0 : uf_m);
      n_m  = n_m + 1;
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    int b;
    int p;
    int e_sd;
    b    = (n_m / c_PER) % (2 * c_SLOT);
    p    = b % c_SLOT;
    e_sd = (n_m >= c_FRAME && p >= 1 && p <= 20) ? int'(fs[20-p]) : 0;
    chk("bclk",  int'(i2s_bclk),   (n_m / c_HALF) % 2);
    chk("lrclk", int'(i2s_lrclk),  (b >= c_SLOT) ? 1 : 0);
    chk("sdata", int'(i2s_sdata),  e_sd);
    chk("level", int'(fifo_level), q.size());
    chk("ovf",   int'(overflow),   int'(ov_m));
    chk("udf",   int'(underflow),  int'(uf_m));
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_n(input int target);
    int g;
    g = 0;
    while (n_m < target && g < 40000) begin
      @(negedge clk);
      g++;
    end
    if (n_m != target) chk("wait_target", n_m, target);
  endtask

  task automatic push(input logic [19:0] d);
    sample_in    = d;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
  endtask

  task automatic cap_word(input int base, output logic [31:0] w);
    w = '0;
    for (int b = 1; b <= 32; b++) begin
      wait_n(base + c_PER * b + 4);
      w = {w[30:0], i2s_sdata};
    end
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_bclk"},  int'(i2s_bclk),   0);
    chk({tag, "_lrclk"}, int'(i2s_lrclk),  0);
    chk({tag, "_sdata"}, int'(i2s_sdata),  0);
    chk({tag, "_level"}, int'(fifo_level), 0);
    chk({tag, "_ovf"},   int'(overflow),   0);
    chk({tag, "_udf"},   int'(underflow),  0);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [31:0] w;
    rst_n        = 1'b0;
    sample_in    = '0;
    sample_valid = 1'b0;
    clear_flags  = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Idle timing with no samples
    wait_n(3);   chk("bclk_before_rise", int'(i2s_bclk), 0);
    wait_n(4);   chk("bclk_first_rise",  int'(i2s_bclk), 1);
    wait_n(8);   chk("bclk_first_fall",  int'(i2s_bclk), 0);
    wait_n(256); chk("lrclk_right",      int'(i2s_lrclk), 1);
    wait_n(511); chk("udf_before_wrap",  int'(underflow), 0);
    wait_n(512); chk("udf_first_wrap",   int'(underflow), 1);

    // Single sample 20'h80001 in both slots
    wait_n(600);
    push(20'h80001);
    chk("level_one", int'(fifo_level), 1);
    cap_word(1024, w);
    chk("left_word_80001",  int'(w), int'(32'h80001000));
    cap_word(1024 + 256, w);
    chk("right_word_80001", int'(w), int'(32'h80001000));

    // Six back-to-back pushes into a depth-4 FIFO
    wait_n(1600);
    for (int i = 0; i < 6; i++) push(20'(32'h10 + i * 32'h111));
    chk("level_full", int'(fifo_level), 4);
    chk("ovf_set",    int'(overflow),   1);
    pulse_clear();
    @(negedge clk);
    chk("ovf_cleared", int'(overflow),  0);
    chk("udf_cleared", int'(underflow), 0);

    // Push landing exactly on the pop edge with level 2
    wait_n(4200);
    push(20'hAAAAA);
    push(20'h55555);
    wait_n(4607);
    push(20'h0F0F0);
    chk("level_pop_push", int'(fifo_level), 2);

    // Underflow substitute after sending 20'h12345
    wait_n(5700);
    pulse_clear();
    wait_n(5800);
    push(20'h12345);
    wait_n(6200);
    chk("udf_clear_before", int'(underflow), 0);
    cap_word(6656, w);
`ifdef I2S_TX_UNDERFLOW_HOLD_EN
    chk("udf_subst_word", int'(w), int'(32'h12345000));
`else
    chk("udf_subst_word", int'(w), 0);
`endif
    chk("udf_after_hold", int'(underflow), 1);
    pulse_clear();
    @(negedge clk);
    chk("udf_clear_after", int'(underflow), 0);

    // Random traffic
    while (n_m < 15000) begin
      sample_in    = 20'($urandom);
      sample_valid = ($urandom_range(0, 99) == 0);
      clear_flags  = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    sample_valid = 1'b0;
    clear_flags  = 1'b0;

    // Reset in the middle of a right slot
    wait_n(15040);
    push(20'h7FFFF);
    wait_n(30 * c_FRAME + c_PER * 40);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midreset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_n(4);   chk("restart_first_rise", int'(i2s_bclk), 1);
    wait_n(511); chk("restart_udf_before", int'(underflow), 0);
    wait_n(512); chk("restart_udf_wrap",   int'(underflow), 1);
    wait_n(700);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
